// File: rtl/seg7_pkg.sv
// seg7_pkg
//  Shared constants for the seven-segment scan driver:
//    SEG_BLANK  - all segments off (active-low)
//    AN_OFF     - all anodes off (active-low)
//    SEG_CODES  - 16-entry hex digit table, bit order {g,f,e,d,c,b,a}, active-low
//    state_t    - scan FSM encoding (BLANK gap / DRIVE digit)
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
//  Combinational nibble to seven-segment decoder (common anode, active-low).
//  Ports:
//    i_nibble  in  4  hex digit value
//    o_seg     out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_CODES[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//  Captures a 16-bit value on a load strobe and shows it as four hex digits on
//  a multiplexed common-anode seven-segment display. Each digit slot lasts
//  REFRESH_DIV cycles; the first BLANK_CYCLES of every slot keep all anodes
//  off so the previous digit cannot ghost into the next. Optional leading-zero
//  blanking suppresses upper zero digits (digit 0 is always shown).
//  Ports:
//    clk       in   1   system clock
//    reset     in   1   asynchronous, active-low reset
//    data_in   in   16  value to display
//    load      in   1   capture data_in at this clock edge
//    blank_lz  in   1   1 = suppress leading zero digits
//    seg       out  7   {g,f,e,d,c,b,a}, active-low, registered
//    an        out  4   digit anodes, active-low, an[0] = low nibble, registered
//    dp        out  1   decimal point, active-low, always off
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES - 1);

    logic [15:0]   r_shown_val;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;
    state_t        r_state;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_wrap;
    logic [PW-1:0] w_presc_next;
    logic [1:0]    w_digit_next;
    state_t        w_state_next;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_next;
    logic [3:0]    w_nibble;
    logic [6:0]    w_dec_seg;
    logic [3:0]    w_nib_zero;
    logic [3:0]    w_lz_mask;

    // Leading-zero mask: digit k>0 is hidden when it and every nibble above
    // it are zero. Uses the currently held value, not the one being loaded.
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib_zero
        assign w_nib_zero[gi] = (r_shown_val[4*gi +: 4] == 4'h0);
    end

    assign w_lz_mask[0] = 1'b0;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz_mask
        assign w_lz_mask[gi] = blank_lz & (&w_nib_zero[3:gi]);
    end

    // Outputs are registered from the next-cycle scan position, so the
    // decoder looks at the nibble of the digit about to be driven.
    assign w_nibble = r_shown_val[{w_digit_next, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    // Next-state and output logic
    always_comb begin
        w_wrap       = (r_presc == PRESC_MAX);
        w_presc_next = r_presc + 1'b1;
        w_digit_next = r_digit;
        w_state_next = r_state;
        w_seg_next   = SEG_BLANK;
        w_an_next    = AN_OFF;

        case (r_state)
            BLANK:   if (r_presc == BLANK_END) w_state_next = DRIVE;
            DRIVE:   w_state_next = DRIVE;
            default: w_state_next = BLANK;
        endcase

        // Slot boundary wins over everything: advance digit, reopen the gap.
        if (w_wrap) begin
            w_presc_next = '0;
            w_digit_next = r_digit + 2'd1;
            w_state_next = BLANK;
        end

        if (w_state_next == DRIVE && !w_lz_mask[w_digit_next]) begin
            w_an_next  = ~(4'b0001 << w_digit_next);
            w_seg_next = w_dec_seg;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shown_val <= 16'h0000;
            r_presc     <= '0;
            r_digit     <= 2'd0;
            r_state     <= BLANK;
            r_seg       <= SEG_BLANK;
            r_an        <= AN_OFF;
        end else begin
            if (load) r_shown_val <= data_in;
            r_presc <= w_presc_next;
            r_digit <= w_digit_next;
            r_state <= w_state_next;
            r_seg   <= w_seg_next;
            r_an    <= w_an_next;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//  Directed and randomized stimulus for seg7_scan_driver (REFRESH_DIV=8,
//  BLANK_CYCLES=2). Expected outputs come from a cycle-count model: after the
//  n-th edge since reset release the slot position is n mod 8 and the digit
//  is (n div 8) mod 4; the value shown is whatever was captured before that edge.
module tb_seg7_scan_driver;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    logic [15:0] model_val = 16'h0000;

    logic [6:0] dec_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_driver #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
        end
    endtask

    task automatic check7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // One clock edge plus model update and output comparison.
    task automatic tick();
        logic [15:0] shown;
        int p, d;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       supp;
        shown = model_val;
        if (load) model_val = data_in;
        @(posedge clk);
        n++;
        #1;
        p = n % RDIV;
        d = (n / RDIV) % 4;
        exp_an  = 4'b1111;
        exp_seg = 7'h7F;
        if (p >= BLANK) begin
            nib  = 4'((shown >> (4 * d)) & 16'h000F);
            supp = blank_lz && (d > 0) && ((shown >> (4 * d)) == 16'h0000);
            if (!supp) begin
                exp_an  = 4'b1111 ^ 4'(1 << d);
                exp_seg = dec_tab[nib];
            end
        end
        check4("an", an, exp_an);
        check7("seg", seg, exp_seg);
        checks++;
        assert ($countones(~an) <= 1 && dp === 1'b1) else begin
            failures++;
            $error("FAIL onehot_dp n=%0d got an=%b dp=%b exp <=1 low anode dp=1", n, an, dp);
        end
        $display("n=%0d load=%0b data=%h lz=%0b an=%b seg=%h exp_an=%b exp_seg=%h",
                 n, load, data_in, blank_lz, an, seg, exp_an, exp_seg);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic load_val(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    int guard;

    initial begin
        reset    = 1'b0;
        data_in  = 16'h0000;
        load     = 1'b0;
        blank_lz = 1'b0;

        // 1. reset held for 15 ns, outputs off during reset
        #8;
        check4("rst_an", an, 4'b1111);
        check7("rst_seg", seg, 7'h7F);
        #7;
        reset = 1'b1;
        run(2);
        check4("first_an", an, 4'b1110);
        check7("first_seg", seg, 7'h40);
        run(6);

        // 2. single-cycle load of 1234, full refresh period
        load_val(16'h1234);
        run(4 * RDIV);

        // 3. ABCD without blanking
        load_val(16'hABCD);
        run(4 * RDIV);

        // 4. leading-zero blanking cases
        blank_lz = 1'b1;
        load_val(16'h0005);
        run(4 * RDIV);
        load_val(16'h0000);
        run(4 * RDIV);
        load_val(16'h0F00);
        run(4 * RDIV);
        blank_lz = 1'b0;

        // 5. FFFF loaded mid-DRIVE on digit 2
        guard = 0;
        while (!((n % RDIV) == 3 && ((n / RDIV) % 4) == 2) && guard < 64) begin
            tick();
            guard++;
        end
        checks++;
        assert (guard < 64) else begin
            failures++;
            $error("FAIL wait_digit2 got guard=%0d exp <64", guard);
        end
        load_val(16'hFFFF);
        tick();
        check7("mid_load_seg", seg, 7'h0E);
        check4("mid_load_an", an, 4'b1011);

        // 6. async reset mid-DRIVE on digit 3
        guard = 0;
        while (!((n % RDIV) == 4 && ((n / RDIV) % 4) == 3) && guard < 64) begin
            tick();
            guard++;
        end
        check4("pre_rst_an", an, 4'b0111);
        #2;
        reset = 1'b0;
        #1;
        check4("async_rst_an", an, 4'b1111);
        check7("async_rst_seg", seg, 7'h7F);
        @(negedge clk);
        reset     = 1'b1;
        n         = 0;
        model_val = 16'h0000;
        run(2);
        check4("restart_an", an, 4'b1110);
        check7("restart_seg", seg, 7'h40);

        // Randomized loads, data and blanking mode
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom_range(0, 7) == 0);
            data_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00FF;
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            tick();
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
